// File: rtl/custom_result_writer_pkg.sv
// Shared definitions for the Custom convolution write-back path: state
// encoding, bus widths and the default result base address.
package custom_pkg;

  localparam int ADDR_W  = 6;
  localparam int DATA_W  = 8;
  localparam int NUM_OUT = 4;
  localparam int IDX_W   = 2;

  localparam logic [ADDR_W-1:0] CUSTOM_RESULT_BASE = 6'd48;
  localparam logic [IDX_W-1:0]  LAST_IDX           = IDX_W'(NUM_OUT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } writer_state_t;

  // Result words sit contiguously above the base, so a beat index maps
  // straight onto an address offset.
  function automatic logic [ADDR_W-1:0] beat_addr(input logic [ADDR_W-1:0] base,
                                                  input logic [IDX_W-1:0]  idx);
    return base + ADDR_W'(idx);
  endfunction

endpackage

// File: rtl/custom_result_writer_if.sv
// Memory write bus between the result writer (master) and the shared
// 64x8 data memory (slave).
interface custom_result_writer_if;
  import custom_pkg::*;

  logic [ADDR_W-1:0] addr_o;
  logic [DATA_W-1:0] data_o;
  logic              we_o;
  logic              wr_ready_i;

  modport master (
    output addr_o,
    output data_o,
    output we_o,
    input  wr_ready_i
  );

  modport slave (
    input  addr_o,
    input  data_o,
    input  we_o,
    output wr_ready_i
  );

endinterface

// File: rtl/custom_result_writer.sv
// Write-back engine: captures the four convolution results on a start pulse
// and writes them row-major into data memory, then pulses is_done_o once.
module custom_result_writer
  import custom_pkg::*;
#(
  parameter logic [ADDR_W-1:0] BASE_ADDR = CUSTOM_RESULT_BASE
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic [DATA_W-1:0]      c11,
  input  logic [DATA_W-1:0]      c12,
  input  logic [DATA_W-1:0]      c21,
  input  logic [DATA_W-1:0]      c22,
  custom_result_writer_if.master bus,
  output logic                   busy_o,
  output logic                   is_done_o
);

  writer_state_t     state;
  logic [IDX_W-1:0]  idx;
  logic [DATA_W-1:0] r [NUM_OUT];

  logic beat_accept;
  assign beat_accept = bus.we_o && bus.wr_ready_i;

  // Single registered FSM; every output is a flop so the top-level address
  // mux sees clean signals. Results are taken from the capture bank, never
  // from the live c-inputs, once the transfer has started.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      idx        <= '0;
      bus.addr_o <= '0;
      bus.data_o <= '0;
      bus.we_o   <= 1'b0;
      busy_o     <= 1'b0;
      is_done_o  <= 1'b0;
      for (int i = 0; i < NUM_OUT; i++) begin
        r[i] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          is_done_o <= 1'b0;
          if (en) begin
            r[0]       <= c11;
            r[1]       <= c12;
            r[2]       <= c21;
            r[3]       <= c22;
            idx        <= '0;
            bus.addr_o <= beat_addr(BASE_ADDR, '0);
            bus.data_o <= c11;
            bus.we_o   <= 1'b1;
            busy_o     <= 1'b1;
            state      <= WRITE;
          end
        end

        // Address/data/we simply hold while the memory stalls.
        WRITE: begin
          if (beat_accept) begin
            if (idx != LAST_IDX) begin
              idx        <= idx + 2'd1;
              bus.addr_o <= beat_addr(BASE_ADDR, idx + 2'd1);
              bus.data_o <= r[idx + 2'd1];
            end else begin
              bus.we_o  <= 1'b0;
              is_done_o <= 1'b1;
              state     <= DONE;
            end
          end
        end

        DONE: begin
          is_done_o <= 1'b0;
          busy_o    <= 1'b0;
          state     <= IDLE;
        end

        default: begin
          state     <= IDLE;
          bus.we_o  <= 1'b0;
          busy_o    <= 1'b0;
          is_done_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_custom_result_writer.sv
// Self-checking bench for custom_result_writer: table-driven transfers with a
// write scoreboard, plus hand-written reset corner cases.
module tb_custom_result_writer;
  import custom_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       ready;
  logic [7:0] c11, c12, c21, c22;
  logic       busy_a, done_a, busy_b, done_b;
  logic       use_b;

  custom_result_writer_if bus_a ();
  custom_result_writer_if bus_b ();

  assign bus_a.wr_ready_i = ready;
  assign bus_b.wr_ready_i = ready;

  custom_result_writer dut_a (
    .clk(clk), .rst(rst), .en(en),
    .c11(c11), .c12(c12), .c21(c21), .c22(c22),
    .bus(bus_a), .busy_o(busy_a), .is_done_o(done_a)
  );

  custom_result_writer #(.BASE_ADDR(6'd60)) dut_b (
    .clk(clk), .rst(rst), .en(en),
    .c11(c11), .c12(c12), .c21(c21), .c22(c22),
    .bus(bus_b), .busy_o(busy_b), .is_done_o(done_b)
  );

  always #5 clk = ~clk;

  logic [5:0] sel_addr;
  logic [7:0] sel_data;
  logic       sel_we, sel_busy, sel_done;
  assign sel_addr = use_b ? bus_b.addr_o : bus_a.addr_o;
  assign sel_data = use_b ? bus_b.data_o : bus_a.data_o;
  assign sel_we   = use_b ? bus_b.we_o   : bus_a.we_o;
  assign sel_busy = use_b ? busy_b       : busy_a;
  assign sel_done = use_b ? done_b       : done_a;

  typedef struct {
    logic [7:0] c11, c12, c21, c22;
    int         stall_beat;
    int         stall_len;
    bit         change_after;
    bit         repulse;
    bit         use_b;
    logic [5:0] base;
    int         exp_done;
  } vec_t;

  typedef struct {
    logic [5:0] addr;
    logic [7:0] data;
  } beat_t;

  vec_t  vecs[6];
  beat_t sb_q[$];
  int    pass_cnt = 0;
  int    total_cnt = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Starts a transfer in the current cycle, then plays ready per cycle,
  // popping the scoreboard on every accepted beat.
  task automatic applyStimulus(input vec_t v);
    int    stalls_left;
    int    beats;
    int    done_cnt;
    int    done_at;
    int    busy_cyc;
    beat_t b;
    stalls_left = v.stall_len;
    beats = 0; done_cnt = 0; done_at = -1; busy_cyc = 0;
    use_b = v.use_b;
    c11 = v.c11; c12 = v.c12; c21 = v.c21; c22 = v.c22;
    en = 1'b1;
    ready = 1'b1;
    sb_q.push_back('{v.base + 6'd0, v.c11});
    sb_q.push_back('{v.base + 6'd1, v.c12});
    sb_q.push_back('{v.base + 6'd2, v.c21});
    sb_q.push_back('{v.base + 6'd3, v.c22});
    for (int t = 1; t <= v.exp_done + 3; t++) begin
      step();
      en = v.repulse && (t == 2 || t == v.exp_done);
      if (t == 1 && v.change_after) begin
        c11 = 8'hFF; c12 = 8'hFF; c21 = 8'hFF; c22 = 8'hFF;
      end
      if (sel_done) begin done_cnt++; done_at = t; end
      if (sel_busy) busy_cyc++;
      if (sel_we) begin
        if (sb_q.size() == 0) begin
          checkOutput("extra_write", 32'(sel_addr), 32'hFFFF);
          ready = 1'b1;
        end else if (beats == v.stall_beat && stalls_left > 0) begin
          ready = 1'b0;
          stalls_left--;
          checkOutput("stall_addr", 32'(sel_addr), 32'(sb_q[0].addr));
          checkOutput("stall_data", 32'(sel_data), 32'(sb_q[0].data));
        end else begin
          ready = 1'b1;
          b = sb_q.pop_front();
          checkOutput("wr_addr", 32'(sel_addr), 32'(b.addr));
          checkOutput("wr_data", 32'(sel_data), 32'(b.data));
          beats++;
        end
      end else begin
        ready = 1'b1;
      end
    end
    en = 1'b0;
    checkOutput("beat_count", 32'(beats), 32'd4);
    checkOutput("done_count", 32'(done_cnt), 32'd1);
    checkOutput("done_cycle", 32'(done_at), 32'(v.exp_done));
    checkOutput("busy_cycles", 32'(busy_cyc), 32'(v.exp_done));
    checkOutput("sb_empty", 32'(sb_q.size()), 32'd0);
    sb_q.delete();
    use_b = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0] = '{8'h11, 8'h22, 8'h33, 8'h44, -1, 0, 1'b0, 1'b0, 1'b0, 6'd48, 5};
    vecs[1] = '{8'h11, 8'h22, 8'h33, 8'h44,  1, 3, 1'b0, 1'b0, 1'b0, 6'd48, 8};
    vecs[2] = '{8'h11, 8'h22, 8'h33, 8'h44, -1, 0, 1'b1, 1'b0, 1'b0, 6'd48, 5};
    vecs[3] = '{8'hA5, 8'h5A, 8'hC3, 8'h3C, -1, 0, 1'b0, 1'b1, 1'b0, 6'd48, 5};
    vecs[4] = '{8'h00, 8'hFF, 8'h80, 8'h7F,  3, 1, 1'b0, 1'b0, 1'b0, 6'd48, 6};
    vecs[5] = '{8'h01, 8'h02, 8'h03, 8'h04, -1, 0, 1'b0, 1'b0, 1'b1, 6'd60, 5};

    use_b = 1'b0;
    rst = 1'b1; en = 1'b0; ready = 1'b1;
    c11 = 8'h0; c12 = 8'h0; c21 = 8'h0; c22 = 8'h0;
    step();
    checkOutput("rst_we",   32'(bus_a.we_o),   32'd0);
    checkOutput("rst_addr", 32'(bus_a.addr_o), 32'd0);
    checkOutput("rst_data", 32'(bus_a.data_o), 32'd0);
    checkOutput("rst_busy", 32'(busy_a),       32'd0);
    checkOutput("rst_done", 32'(done_a),       32'd0);
    checkOutput("rst_b_we", 32'(bus_b.we_o),   32'd0);
    step();
    rst = 1'b0;
    step();

    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i]);
      step();
    end

    // Reset after the second accepted beat abandons the transfer.
    c11 = 8'h11; c12 = 8'h22; c21 = 8'h33; c22 = 8'h44;
    en = 1'b1;
    step();
    en = 1'b0;
    checkOutput("abort_b0_addr", 32'(bus_a.addr_o), 32'd48);
    checkOutput("abort_b0_we",   32'(bus_a.we_o),   32'd1);
    step();
    checkOutput("abort_b1_addr", 32'(bus_a.addr_o), 32'd49);
    checkOutput("abort_b1_data", 32'(bus_a.data_o), 32'h22);
    step();
    checkOutput("abort_b2_addr", 32'(bus_a.addr_o), 32'd50);
    rst = 1'b1;
    ready = 1'b0;
    step();
    rst = 1'b0;
    ready = 1'b1;
    checkOutput("abort_we",   32'(bus_a.we_o),   32'd0);
    checkOutput("abort_busy", 32'(busy_a),       32'd0);
    checkOutput("abort_addr", 32'(bus_a.addr_o), 32'd0);
    begin
      int late_done = 0;
      int late_we = 0;
      for (int k = 0; k < 5; k++) begin
        if (done_a) late_done++;
        if (bus_a.we_o) late_we++;
        step();
      end
      checkOutput("abort_no_done", 32'(late_done), 32'd0);
      checkOutput("abort_no_we",   32'(late_we),   32'd0);
    end
    applyStimulus(vecs[0]);
    step();

    // Reset wins over a simultaneous start.
    en = 1'b1;
    rst = 1'b1;
    step();
    en = 1'b0;
    rst = 1'b0;
    checkOutput("rst_en_we",   32'(bus_a.we_o), 32'd0);
    checkOutput("rst_en_busy", 32'(busy_a),     32'd0);
    step();
    checkOutput("rst_en_we2",   32'(bus_a.we_o), 32'd0);
    checkOutput("rst_en_busy2", 32'(busy_a),     32'd0);
    checkOutput("rst_en_done2", 32'(done_a),     32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
